// File: rtl/ctrl_to_axilite.sv
// ctrl_to_axilite
//   Host-side initiator for the emulator control register map. Turns simple
//   ctrl_* word read/write requests into AXI4-Lite master transactions, one
//   transaction in flight at a time, in order, with writes taking priority
//   over reads when both arrive together.
// Ports
//   host_clk, host_rst_n        clock, asynchronous active-low reset
//   ctrl_wen/waddr/wdata        write request (word address), sampled when idle
//   ctrl_ren/raddr              read request (word address), sampled when idle
//   ctrl_busy                   a transaction is in flight; new requests dropped
//   ctrl_wdone / ctrl_rvalid    1-cycle completion pulses
//   ctrl_rdata                  last read data, held until the next read completes
//   ctrl_err                    qualifies the completion pulse: response not OKAY
//   m_axilite_*                 AXI4-Lite master (byte address = word address * 4)
module ctrl_to_axilite #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    host_clk,
  input  logic                    host_rst_n,
  input  logic                    ctrl_wen,
  input  logic [ADDR_WIDTH-3:0]   ctrl_waddr,
  input  logic [DATA_WIDTH-1:0]   ctrl_wdata,
  input  logic                    ctrl_ren,
  input  logic [ADDR_WIDTH-3:0]   ctrl_raddr,
  output logic                    ctrl_busy,
  output logic                    ctrl_wdone,
  output logic                    ctrl_rvalid,
  output logic [DATA_WIDTH-1:0]   ctrl_rdata,
  output logic                    ctrl_err,
  output logic                    m_axilite_awvalid,
  input  logic                    m_axilite_awready,
  output logic [ADDR_WIDTH-1:0]   m_axilite_awaddr,
  output logic [2:0]              m_axilite_awprot,
  output logic                    m_axilite_wvalid,
  input  logic                    m_axilite_wready,
  output logic [DATA_WIDTH-1:0]   m_axilite_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axilite_wstrb,
  input  logic                    m_axilite_bvalid,
  output logic                    m_axilite_bready,
  input  logic [1:0]              m_axilite_bresp,
  output logic                    m_axilite_arvalid,
  input  logic                    m_axilite_arready,
  output logic [ADDR_WIDTH-1:0]   m_axilite_araddr,
  output logic [2:0]              m_axilite_arprot,
  input  logic                    m_axilite_rvalid,
  output logic                    m_axilite_rready,
  input  logic [DATA_WIDTH-1:0]   m_axilite_rdata,
  input  logic [1:0]              m_axilite_rresp
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-3:0]   waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                    bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                    wdone_q, wdone_d, rvalid_q, rvalid_d, err_q, err_d;

  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wdone_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_pend_q <= rd_pend_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wdone_q   <= wdone_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_pend_d = rd_pend_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    wdone_d   = 1'b0;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_wen) begin
          waddr_d   = ctrl_waddr;
          wdata_d   = ctrl_wdata;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR;
          // A simultaneous read is parked and issued after the write response.
          if (ctrl_ren) begin
            raddr_d   = ctrl_raddr;
            rd_pend_d = 1'b1;
          end
        end else if (ctrl_ren) begin
          raddr_d   = ctrl_raddr;
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      WR: begin
        // AW and W retire independently; move on once neither is still pending.
        awvalid_d = awvalid_q & ~m_axilite_awready;
        wvalid_d  = wvalid_q & ~m_axilite_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready_q && m_axilite_bvalid) begin
          bready_d = 1'b0;
          wdone_d  = 1'b1;
          err_d    = (m_axilite_bresp != 2'b00);
          if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RD_ADDR: begin
        if (m_axilite_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rready_q && m_axilite_rvalid) begin
          rdata_d  = m_axilite_rdata;
          rready_d = 1'b0;
          rvalid_d = 1'b1;
          err_d    = (m_axilite_rresp != 2'b00);
          state_d  = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        rd_pend_d = 1'b0;
      end
    endcase
  end

  assign ctrl_busy         = (state_q != IDLE);
  assign ctrl_wdone        = wdone_q;
  assign ctrl_rvalid       = rvalid_q;
  assign ctrl_rdata        = rdata_q;
  assign ctrl_err          = err_q;
  assign m_axilite_awvalid = awvalid_q;
  assign m_axilite_awaddr  = {waddr_q, 2'b00};
  assign m_axilite_awprot  = 3'b000;
  assign m_axilite_wvalid  = wvalid_q;
  assign m_axilite_wdata   = wdata_q;
  assign m_axilite_wstrb   = '1;
  assign m_axilite_bready  = bready_q;
  assign m_axilite_arvalid = arvalid_q;
  assign m_axilite_araddr  = {raddr_q, 2'b00};
  assign m_axilite_arprot  = 3'b000;
  assign m_axilite_rready  = rready_q;

endmodule
